// File: rtl/agnus_blitter_shiftseq.sv
// Blitter A/B shift sequencer: shares one external barrel shifter between
// channels A and B. It masks the first and last word of each line on A,
// carries the previous A/B words across words and lines, and hands shifted
// pairs to the minterm/fill stage.
//
// Ports:
//   clk, clk7_en, reset        clock, clock enable, sync active-high reset
//   start, desc, ash, bsh,     blit configuration, latched when a blit starts
//   bltw, blth, afwm, alwm
//   in_valid/in_ready, a_in,   fetched word pair handshake
//   b_in
//   sh_desc, sh_shift, sh_new, drive the shared shifter; sh_out is its
//   sh_old, sh_out             combinational result
//   out_valid/out_ready,       shifted pair handshake
//   a_out, b_out
//   first_w, last_w, last_l    position of the word currently on a_out/b_out
//   busy, done                 blit in progress / end-of-blit pulse
module agnus_blitter_shiftseq #(
    parameter int unsigned WW = 6,
    parameter int unsigned HW = 10
) (
    input  logic          clk,
    input  logic          clk7_en,
    input  logic          reset,
    input  logic          start,
    input  logic          desc,
    input  logic [3:0]    ash,
    input  logic [3:0]    bsh,
    input  logic [WW-1:0] bltw,
    input  logic [HW-1:0] blth,
    input  logic [15:0]   afwm,
    input  logic [15:0]   alwm,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   a_in,
    input  logic [15:0]   b_in,
    output logic          sh_desc,
    output logic [3:0]    sh_shift,
    output logic [15:0]   sh_new,
    output logic [15:0]   sh_old,
    input  logic [15:0]   sh_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   a_out,
    output logic [15:0]   b_out,
    output logic          first_w,
    output logic          last_w,
    output logic          last_l,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SHA,
        S_SHB,
        S_OUT,
        S_DONE
    } state_t;

    state_t        state;
    logic [3:0]    cfg_ash;
    logic [3:0]    cfg_bsh;
    logic [WW-1:0] cfg_w;
    logic [HW-1:0] cfg_h;
    logic [15:0]   cfg_afwm;
    logic [15:0]   cfg_alwm;
    logic [15:0]   a_old;
    logic [15:0]   b_old;
    logic [15:0]   a_new;
    logic [15:0]   b_new;
    logic [WW-1:0] widx;
    logic [HW-1:0] lidx;

    logic          is_first;
    logic          is_last_w;
    logic          is_last_l;
    logic [15:0]   a_masked;

    // Position of the word being accepted. A width/height of 0 wraps to
    // all-ones after the -1, which is exactly the 2**W encoding.
    always_comb begin
        is_first  = 1'b0;
        is_last_w = 1'b0;
        is_last_l = 1'b0;
        a_masked  = a_in;
        is_first  = (widx == '0);
        is_last_w = (widx == cfg_w - WW'(1));
        is_last_l = (lidx == cfg_h - HW'(1));
        if (is_first) begin
            a_masked = a_masked & cfg_afwm;
        end
        if (is_last_w) begin
            a_masked = a_masked & cfg_alwm;
        end
    end

    // Sequencer: WAIT -> SHA (A on shifter) -> SHB (B on shifter) -> OUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cfg_ash   <= '0;
            cfg_bsh   <= '0;
            cfg_w     <= '0;
            cfg_h     <= '0;
            cfg_afwm  <= '0;
            cfg_alwm  <= '0;
            a_old     <= '0;
            b_old     <= '0;
            a_new     <= '0;
            b_new     <= '0;
            widx      <= '0;
            lidx      <= '0;
            in_ready  <= 1'b0;
            sh_desc   <= 1'b0;
            sh_shift  <= '0;
            sh_new    <= '0;
            sh_old    <= '0;
            out_valid <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            first_w   <= 1'b0;
            last_w    <= 1'b0;
            last_l    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (clk7_en) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cfg_ash  <= ash;
                        cfg_bsh  <= bsh;
                        cfg_w    <= bltw;
                        cfg_h    <= blth;
                        cfg_afwm <= afwm;
                        cfg_alwm <= alwm;
                        a_old    <= '0;
                        b_old    <= '0;
                        widx     <= '0;
                        lidx     <= '0;
                        sh_desc  <= desc;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (in_valid) begin
                        a_new    <= a_masked;
                        b_new    <= b_in;
                        sh_new   <= a_masked;
                        sh_old   <= a_old;
                        sh_shift <= cfg_ash;
                        first_w  <= is_first;
                        last_w   <= is_last_w;
                        last_l   <= is_last_l;
                        in_ready <= 1'b0;
                        state    <= S_SHA;
                    end
                end
                S_SHA: begin
                    a_out    <= sh_out;
                    a_old    <= a_new;
                    sh_new   <= b_new;
                    sh_old   <= b_old;
                    sh_shift <= cfg_bsh;
                    state    <= S_SHB;
                end
                S_SHB: begin
                    b_out     <= sh_out;
                    b_old     <= b_new;
                    sh_new    <= '0;
                    sh_old    <= '0;
                    sh_shift  <= '0;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_w) begin
                            widx <= '0;
                            lidx <= lidx + HW'(1);
                        end else begin
                            widx <= widx + WW'(1);
                        end
                        if (last_w && last_l) begin
                            busy    <= 1'b0;
                            sh_desc <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_agnus_blitter_shiftseq.sv
// Directed bench for agnus_blitter_shiftseq. Includes a behavioural model of
// the shared barrel shifter driving sh_out from the sequencer's sh_* outputs.
module tb_agnus_blitter_shiftseq;

    logic        clk = 1'b0;
    logic        clk7_en = 1'b1;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        desc = 1'b0;
    logic [3:0]  ash = '0;
    logic [3:0]  bsh = '0;
    logic [5:0]  bltw = '0;
    logic [9:0]  blth = '0;
    logic [15:0] afwm = '0;
    logic [15:0] alwm = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        sh_desc;
    logic [3:0]  sh_shift;
    logic [15:0] sh_new;
    logic [15:0] sh_old;
    logic [15:0] sh_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic        first_w;
    logic        last_w;
    logic        last_l;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic en_toggle = 1'b0;

    agnus_blitter_shiftseq #(.WW(6), .HW(10)) dut (
        .clk(clk), .clk7_en(clk7_en), .reset(reset), .start(start), .desc(desc),
        .ash(ash), .bsh(bsh), .bltw(bltw), .blth(blth), .afwm(afwm), .alwm(alwm),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
        .sh_desc(sh_desc), .sh_shift(sh_shift), .sh_new(sh_new), .sh_old(sh_old),
        .sh_out(sh_out), .out_valid(out_valid), .out_ready(out_ready),
        .a_out(a_out), .b_out(b_out), .first_w(first_w), .last_w(last_w),
        .last_l(last_l), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Shifter model: asc new>>s | old<<(16-s); desc new<<s | old>>(16-s).
    logic [4:0] inv_sh;
    always_comb begin
        inv_sh = 5'd16 - {1'b0, sh_shift};
        if (sh_desc) sh_out = (sh_new << sh_shift) | (sh_old >> inv_sh);
        else         sh_out = (sh_new >> sh_shift) | (sh_old << inv_sh);
    end

    // Enable toggles on the falling edge, away from the sampling point.
    initial forever begin
        @(negedge clk);
        clk7_en = en_toggle ? ~clk7_en : 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_blit(input logic d, input logic [3:0] sa, input logic [3:0] sb,
                              input logic [5:0] w, input logic [9:0] h,
                              input logic [15:0] fm, input logic [15:0] lm);
        desc = d; ash = sa; bsh = sb; bltw = w; blth = h; afwm = fm; alwm = lm;
        start = 1'b1;
        for (int i = 0; i < 10 && !busy; i++) tick();
        start = 1'b0;
        desc = 1'b0; ash = '0; bsh = '0; afwm = '0; alwm = '0;
    endtask

    task automatic send_word(input logic [15:0] a, input logic [15:0] b, output logic ok);
        for (int i = 0; i < 40 && !in_ready; i++) tick();
        ok = in_ready;
        a_in = a; b_in = b; in_valid = 1'b1;
        for (int i = 0; i < 10 && in_ready; i++) tick();
        ok = ok && !in_ready;
        in_valid = 1'b0; a_in = '0; b_in = '0;
    endtask

    task automatic wait_out(output int n, output logic ok);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        ok = out_valid;
    endtask

    task automatic handoff(output logic ok);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && out_valid; i++) tick();
        ok = !out_valid;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({in_ready, out_valid, busy, done, first_w, last_w, last_l, sh_desc,
             sh_shift, sh_new, sh_old, a_out, b_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b in_ready=%b a_out=%h b_out=%h sh_new=%h expected all 0",
                     busy, in_ready, a_out, b_out, sh_new);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ascending();
        logic ok;
        int n;
        start_blit(1'b0, 4'd4, 4'd0, 6'd2, 10'd1, 16'hFFFF, 16'hFFFF);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || sh_desc !== 1'b0) begin
            errors++;
            $display("FAIL asc_start: busy=%b in_ready=%b sh_desc=%b expected 1 1 0", busy, in_ready, sh_desc);
        end
        send_word(16'hABCD, 16'h0000, ok);
        checks++;
        if (!ok || sh_new !== 16'hABCD || sh_old !== 16'h0000 || sh_shift !== 4'd4) begin
            errors++;
            $display("FAIL asc_sha_drive: ok=%b sh_new=%h sh_old=%h sh_shift=%0d expected abcd 0000 4",
                     ok, sh_new, sh_old, sh_shift);
        end
        wait_out(n, ok);
        checks++;
        if (!ok || n !== 2) begin
            errors++;
            $display("FAIL asc_latency: ok=%b cycles=%0d expected 2 after accept", ok, n);
        end
        checks++;
        if (a_out !== 16'h0ABC || first_w !== 1'b1 || last_w !== 1'b0 || last_l !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL asc_word0: a_out=%h fw=%b lw=%b ll=%b in_ready=%b expected 0abc 1 0 1 0",
                     a_out, first_w, last_w, last_l, in_ready);
        end
        handoff(ok);
        send_word(16'h1234, 16'h0000, ok);
        wait_out(n, ok);
        checks++;
        if (!ok || a_out !== 16'hD123 || first_w !== 1'b0 || last_w !== 1'b1) begin
            errors++;
            $display("FAIL asc_word1: ok=%b a_out=%h fw=%b lw=%b expected d123 0 1", ok, a_out, first_w, last_w);
        end
        handoff(ok);
        checks++;
        if (!ok || done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL asc_done: ok=%b done=%b busy=%b in_ready=%b expected 1 0 0", ok, done, busy, in_ready);
        end
        tick();
        checks++;
        if (done !== 1'b0 || sh_desc !== 1'b0) begin
            errors++;
            $display("FAIL asc_done_pulse: done=%b sh_desc=%b expected 0 0", done, sh_desc);
        end
    endtask

    task automatic test_descending();
        logic ok;
        int n;
        start_blit(1'b1, 4'd4, 4'd0, 6'd2, 10'd1, 16'hFFFF, 16'hFFFF);
        send_word(16'hABCD, 16'h0000, ok);
        wait_out(n, ok);
        checks++;
        if (!ok || a_out !== 16'hBCD0 || sh_desc !== 1'b1) begin
            errors++;
            $display("FAIL desc_word0: ok=%b a_out=%h sh_desc=%b expected bcd0 1", ok, a_out, sh_desc);
        end
        handoff(ok);
        send_word(16'h1234, 16'h0000, ok);
        wait_out(n, ok);
        checks++;
        if (!ok || a_out !== 16'h234A) begin
            errors++;
            $display("FAIL desc_word1: ok=%b a_out=%h expected 234a", ok, a_out);
        end
        handoff(ok);
        tick();
    endtask

    task automatic test_single_word_masks();
        logic ok;
        int n;
        start_blit(1'b0, 4'd0, 4'd0, 6'd1, 10'd1, 16'hFF00, 16'h0FF0);
        send_word(16'hFFFF, 16'h5A5A, ok);
        wait_out(n, ok);
        checks++;
        if (!ok || a_out !== 16'h0F00 || b_out !== 16'h5A5A || first_w !== 1'b1 || last_w !== 1'b1 || last_l !== 1'b1) begin
            errors++;
            $display("FAIL mask_w1: ok=%b a_out=%h b_out=%h fw=%b lw=%b ll=%b expected 0f00 5a5a 1 1 1",
                     ok, a_out, b_out, first_w, last_w, last_l);
        end
        handoff(ok);
        checks++;
        if (!ok || done !== 1'b1) begin
            errors++;
            $display("FAIL mask_w1_done: ok=%b done=%b expected 1", ok, done);
        end
        tick();
    endtask

    task automatic test_old_across_lines();
        logic ok;
        int n;
        start_blit(1'b0, 4'd0, 4'd8, 6'd1, 10'd2, 16'hFFFF, 16'hFFFF);
        send_word(16'h0000, 16'h00FF, ok);
        wait_out(n, ok);
        checks++;
        if (!ok || b_out !== 16'h0000 || first_w !== 1'b1 || last_w !== 1'b1 || last_l !== 1'b0) begin
            errors++;
            $display("FAIL lines_l0: ok=%b b_out=%h fw=%b lw=%b ll=%b expected 0000 1 1 0",
                     ok, b_out, first_w, last_w, last_l);
        end
        handoff(ok);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL lines_no_early_done: done=%b busy=%b expected 0 1", done, busy);
        end
        send_word(16'h0000, 16'h1100, ok);
        wait_out(n, ok);
        checks++;
        if (!ok || b_out !== 16'hFF11 || last_l !== 1'b1) begin
            errors++;
            $display("FAIL lines_l1: ok=%b b_out=%h ll=%b expected ff11 1", ok, b_out, last_l);
        end
        handoff(ok);
        tick();
    endtask

    task automatic test_stall();
        logic ok;
        logic seen_done;
        int n;
        start_blit(1'b0, 4'd4, 4'd0, 6'd2, 10'd1, 16'hFFFF, 16'hFFFF);
        en_toggle = 1'b1;
        send_word(16'h1111, 16'h2222, ok);
        wait_out(n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_first_out: out_valid=%b expected 1", out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || a_out !== 16'h0111 || b_out !== 16'h2222) begin
                errors++;
                $display("FAIL stall_hold[%0d]: ov=%b ir=%b a_out=%h b_out=%h expected 1 0 0111 2222",
                         i, out_valid, in_ready, a_out, b_out);
            end
        end
        handoff(ok);
        send_word(16'h3333, 16'h4444, ok);
        wait_out(n, ok);
        checks++;
        if (!ok || a_out !== 16'h1333 || b_out !== 16'h4444 || last_w !== 1'b1) begin
            errors++;
            $display("FAIL stall_second: ok=%b a_out=%h b_out=%h lw=%b expected 1333 4444 1", ok, a_out, b_out, last_w);
        end
        handoff(ok);
        seen_done = 1'b0;
        for (int i = 0; i < 4 && !seen_done; i++) begin
            if (done) seen_done = 1'b1;
            else tick();
        end
        checks++;
        if (!seen_done || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: done_seen=%b busy=%b expected 1 0", seen_done, busy);
        end
        en_toggle = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid_blit();
        logic ok;
        int n;
        start_blit(1'b0, 4'd4, 4'd4, 6'd2, 10'd1, 16'hFFFF, 16'hFFFF);
        send_word(16'hFFFF, 16'hFFFF, ok);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy, done, first_w, last_w, last_l, sh_desc,
             sh_shift, sh_new, sh_old, a_out, b_out} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: busy=%b ov=%b a_out=%h sh_new=%h sh_shift=%0d expected all 0",
                     busy, out_valid, a_out, sh_new, sh_shift);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_done: done=%b busy=%b expected 0 0", done, busy);
        end
        start_blit(1'b0, 4'd4, 4'd4, 6'd1, 10'd1, 16'hFFFF, 16'hFFFF);
        send_word(16'h0F0F, 16'h00F0, ok);
        wait_out(n, ok);
        checks++;
        if (!ok || a_out !== 16'h00F0 || b_out !== 16'h000F) begin
            errors++;
            $display("FAIL midreset_restart: ok=%b a_out=%h b_out=%h expected 00f0 000f", ok, a_out, b_out);
        end
        handoff(ok);
        checks++;
        if (!ok || done !== 1'b1) begin
            errors++;
            $display("FAIL midreset_done: ok=%b done=%b expected 1", ok, done);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_descending();
        test_single_word_masks();
        test_old_across_lines();
        test_stall();
        test_reset_mid_blit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
